// File: rtl/ddc_slv_pkg.sv
// Shared definitions for the DDC (I2C) slave controller: FSM states and bus constants.
package ddc_slv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_AACK,
      ST_WBYTE,
      ST_WACK,
      ST_RBYTE,
      ST_RACK
   } state_t;

   localparam logic       I2C_RW_READ      = 1'b1;
   localparam logic [6:0] DDC_ADDR_DEFAULT = 7'h50;
   localparam logic [2:0] BIT_LAST         = 3'd7;

   function automatic logic state_busy(state_t s);
      return (s == ST_AACK) || (s == ST_WBYTE) || (s == ST_WACK) ||
             (s == ST_RBYTE) || (s == ST_RACK);
   endfunction

endpackage

// File: rtl/ddc_slv_shift.sv
// 8-bit MSB-first shift register with bit counter; shared by receive and transmit paths.
module ddc_slv_shift
   import ddc_slv_pkg::*;
(
   input  logic       ck_ref,
   input  logic       rst_ref,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       shift,
   input  logic       shift_in,
   output logic [7:0] data,
   output logic       last,
   output logic       full
);

   logic [2:0] cnt;

   // full marks eight received bits; last marks the final bit of a transmitted byte
   always_ff @(posedge ck_ref) begin
      if (rst_ref) begin
         data <= '0;
         cnt  <= '0;
         full <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         full <= 1'b0;
      end else if (load) begin
         data <= load_val;
         cnt  <= '0;
         full <= 1'b0;
      end else if (shift) begin
         data <= {data[6:0], shift_in};
         cnt  <= cnt + 3'd1;
         if (cnt == BIT_LAST) full <= 1'b1;
      end
   end

   assign last = (cnt == BIT_LAST);

endmodule

// File: rtl/ddc_slv_ctrl.sv
// DDC/I2C register-access slave: address match, pointer write, auto-incrementing reads/writes.
//  state    | meaning
//  ST_IDLE  | not addressed, SCL edges ignored
//  ST_ADDR  | shifting in address + R/W
//  ST_AACK  | driving address ACK
//  ST_WBYTE | shifting in a write byte (pointer or data)
//  ST_WACK  | driving data ACK
//  ST_RBYTE | transmitting a read byte
//  ST_RACK  | waiting for master ACK/NACK
module ddc_slv_ctrl
   import ddc_slv_pkg::*;
#(
   parameter logic [6:0] SLV_ADDR = DDC_ADDR_DEFAULT
) (
   input  logic       ck_ref,
   input  logic       rst_ref,
   input  logic       i2c_spc_start,
   input  logic       i2c_spc_stop,
   input  logic       i2c_spc_scl_state,
   input  logic       i2c_spc_scl_fall,
   input  logic       i2c_spc_sda_state,
   output logic       i2c_slv_sda_oe,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       rd_done
);

   state_t     state, state_nxt;
   logic       sda_oe, sda_oe_nxt;
   logic [7:0] ptr, ptr_nxt;
   logic       first_wr, first_wr_nxt;
   logic       mack, mack_nxt;
   logic       scl_prev, scl_rise;
   logic       sh_clr, sh_load, sh_shift, sh_in, sh_last, sh_full;
   logic [7:0] sh_data;
   logic       wr_en_c, rd_done_c;

   assign scl_rise = i2c_spc_scl_state & ~scl_prev;

   ddc_slv_shift u_shift (
      .ck_ref   (ck_ref),
      .rst_ref  (rst_ref),
      .clr      (sh_clr),
      .load     (sh_load),
      .load_val (rd_data),
      .shift    (sh_shift),
      .shift_in (sh_in),
      .data     (sh_data),
      .last     (sh_last),
      .full     (sh_full)
   );

   always_ff @(posedge ck_ref) begin
      if (rst_ref) begin
         state    <= ST_IDLE;
         sda_oe   <= 1'b0;
         ptr      <= 8'h00;
         first_wr <= 1'b1;
         mack     <= 1'b1;
         scl_prev <= 1'b0;
      end else begin
         state    <= state_nxt;
         sda_oe   <= sda_oe_nxt;
         ptr      <= ptr_nxt;
         first_wr <= first_wr_nxt;
         mack     <= mack_nxt;
         scl_prev <= i2c_spc_scl_state;
      end
   end

   always_comb begin
      state_nxt    = state;
      sda_oe_nxt   = sda_oe;
      ptr_nxt      = ptr;
      first_wr_nxt = first_wr;
      mack_nxt     = mack;
      sh_clr       = 1'b0;
      sh_load      = 1'b0;
      sh_shift     = 1'b0;
      sh_in        = i2c_spc_sda_state;
      wr_en_c      = 1'b0;
      rd_done_c    = 1'b0;
      if (i2c_spc_start) begin
         state_nxt    = ST_ADDR;
         sh_clr       = 1'b1;
         first_wr_nxt = 1'b1;
         sda_oe_nxt   = 1'b0;
      end else if (i2c_spc_stop) begin
         state_nxt  = ST_IDLE;
         sda_oe_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_ADDR: begin
               if (scl_rise && !sh_full) sh_shift = 1'b1;
               if (i2c_spc_scl_fall && sh_full) begin
                  if (sh_data[7:1] == SLV_ADDR) begin
                     sda_oe_nxt = 1'b1;
                     state_nxt  = ST_AACK;
                  end else begin
                     sda_oe_nxt = 1'b0;
                     state_nxt  = ST_IDLE;
                  end
               end
            end
            ST_AACK: begin
               if (i2c_spc_scl_fall) begin
                  if (sh_data[0] == I2C_RW_READ) begin
                     sh_load    = 1'b1;
                     sda_oe_nxt = ~rd_data[7];
                     state_nxt  = ST_RBYTE;
                  end else begin
                     sh_clr     = 1'b1;
                     sda_oe_nxt = 1'b0;
                     state_nxt  = ST_WBYTE;
                  end
               end
            end
            ST_WBYTE: begin
               if (scl_rise && !sh_full) sh_shift = 1'b1;
               if (i2c_spc_scl_fall && sh_full) begin
                  sda_oe_nxt = 1'b1;
                  state_nxt  = ST_WACK;
                  if (first_wr) begin
                     ptr_nxt      = sh_data;
                     first_wr_nxt = 1'b0;
                  end else begin
                     wr_en_c = 1'b1;
                     ptr_nxt = ptr + 8'd1;
                  end
               end
            end
            ST_WACK: begin
               if (i2c_spc_scl_fall) begin
                  sh_clr     = 1'b1;
                  sda_oe_nxt = 1'b0;
                  state_nxt  = ST_WBYTE;
               end
            end
            ST_RBYTE: begin
               // bit 6 becomes the MSB after this shift, so it is the next bit on the wire
               sh_in = 1'b0;
               if (i2c_spc_scl_fall) begin
                  if (sh_last) begin
                     sh_clr     = 1'b1;
                     sda_oe_nxt = 1'b0;
                     rd_done_c  = 1'b1;
                     ptr_nxt    = ptr + 8'd1;
                     state_nxt  = ST_RACK;
                  end else begin
                     sh_shift   = 1'b1;
                     sda_oe_nxt = ~sh_data[6];
                  end
               end
            end
            ST_RACK: begin
               if (scl_rise) mack_nxt = i2c_spc_sda_state;
               if (i2c_spc_scl_fall) begin
                  if (!mack) begin
                     sh_load    = 1'b1;
                     sda_oe_nxt = ~rd_data[7];
                     state_nxt  = ST_RBYTE;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign i2c_slv_sda_oe = sda_oe;
   assign rd_addr        = ptr;
   assign busy           = state_busy(state) & ~rst_ref;
   assign wr_en          = wr_en_c & ~rst_ref;
   assign wr_addr        = wr_en ? ptr : 8'h00;
   assign wr_data        = wr_en ? sh_data : 8'h00;
   assign rd_done        = rd_done_c & ~rst_ref;

endmodule

// File: doc/ddc_slv_ctrl.md
DDC_SLV_CTRL -- requirements
Module: ddc_slv_ctrl

Interface
REQ-001 Parameter SLV_ADDR, default 7'h50, 7-bit slave address this block responds to.
REQ-002 ck_ref  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ref  input  1  reset, synchronous and active-high.
REQ-004 i2c_spc_start  input  1  one-cycle pulse: START or repeated START detected by the pin controller.
REQ-005 i2c_spc_stop  input  1  one-cycle pulse: STOP detected.
REQ-006 i2c_spc_scl_state  input  1  filtered SCL level.
REQ-007 i2c_spc_scl_fall  input  1  one-cycle pulse on filtered SCL falling edge.
REQ-008 i2c_spc_sda_state  input  1  filtered SDA level.
REQ-009 i2c_slv_sda_oe  output  1  1 = pull SDA low.
REQ-010 rd_addr  output  8  register pointer presented to the register file.
REQ-011 rd_data  input  8  register file read data; valid within 1 ck_ref cycle of a rd_addr change.
REQ-012 wr_en  output  1  one-cycle write strobe.
REQ-013 wr_addr / wr_data  output  8 / 8  write address and data; valid while wr_en=1.
REQ-014 busy  output  1  1 while addressed, from address ACK until STOP, START or IDLE.
REQ-015 rd_done  output  1  one-cycle pulse after each transmitted read byte.

Function
REQ-016 The block SHALL derive scl_rise internally as scl_state=1 with its previous-cycle value=0.
REQ-017 SDA SHALL be sampled only on scl_rise, and i2c_slv_sda_oe SHALL change only on scl_fall, START or STOP.
REQ-018 FSM states SHALL be IDLE, ADDR, AACK, WBYTE, WACK, RBYTE, RACK.
REQ-019 i2c_spc_start from any state SHALL go to ADDR, clear the 3-bit bit counter, set first_wr=1, and release SDA.
REQ-020 i2c_spc_stop from any state SHALL go to IDLE and release SDA.
REQ-021 If START and STOP pulse in the same cycle, START SHALL win.
REQ-022 ADDR: the block SHALL shift in 8 bits MSB first; on the scl_fall after the 8th bit, if bits[7:1]==SLV_ADDR it SHALL set sda_oe=1 and go to AACK, else go to IDLE with SDA released.
REQ-023 AACK, on scl_fall, when R/W=0: release SDA and go to WBYTE.
REQ-024 AACK, on scl_fall, when R/W=1: load the shift register from rd_data, drive bit 7 (sda_oe = ~bit) and go to RBYTE.
REQ-025 WBYTE: shift 8 bits; on the following scl_fall, drive ACK and go to WACK.
REQ-026 In WBYTE with first_wr=1, the received byte SHALL load the pointer and clear first_wr, with no wr_en.
REQ-027 In WBYTE with first_wr=0, wr_en SHALL pulse for exactly 1 cycle in the cycle of that scl_fall, with wr_addr=pointer and wr_data=byte; the pointer SHALL increment in the next cycle.
REQ-028 WACK: on scl_fall, release SDA and return to WBYTE.
REQ-029 RBYTE: on each scl_fall, present the next bit MSB first.
REQ-030 RBYTE, on the scl_fall ending bit 0: release SDA, pulse rd_done, increment the pointer, go to RACK.
REQ-031 RACK: sample master ACK on scl_rise.
REQ-032 RACK, on scl_fall: ACK (SDA=0) SHALL load rd_data at the new pointer and go to RBYTE; NACK SHALL go to IDLE.
REQ-033 Pointer arithmetic SHALL be 8-bit modulo: 8'hFF increments to 8'h00.
REQ-034 The pointer SHALL persist across transactions, so a repeated START followed by a read continues from the written pointer.
REQ-035 scl_fall and scl_rise SHALL be ignored in IDLE.

Reset
REQ-036 With rst_ref=1 the block SHALL force state=IDLE, pointer=8'h00, first_wr=1, bit counter=0, and shift register=0.
REQ-037 With rst_ref=1 every output SHALL be 0: sda_oe, wr_en, rd_done, busy, wr_addr, wr_data; rd_addr SHALL be 8'h00.
REQ-038 Reset mid-transaction SHALL release SDA on the next clock edge.

Structure
REQ-039 A shared package ddc_slv_pkg SHALL hold the FSM state enum and the constants I2C_RW_READ=1 and DDC_ADDR_DEFAULT=7'h50.
REQ-040 One sub-module, ddc_slv_shift (8-bit shift register with bit counter and load/shift/last-bit flags), is natural; the FSM stays in ddc_slv_ctrl.

Verification
REQ-041 Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP -> ACK after each byte; wr_en pulses {0x10:0x5A} then {0x11:0xC3}; rd_addr ends at 0x12.
REQ-042 Random read: pointer=0x20, repeated START, 0xA1, read 3 bytes with ACK, ACK, NACK -> bytes from 0x20, 0x21 and 0x22 on SDA; 3 rd_done pulses; IDLE after NACK; pointer=0x23.
REQ-043 Address mismatch: START, 0xA4 -> sda_oe never asserted; busy=0; no wr_en.
REQ-044 Wrap: pointer=0xFF, read 2 bytes -> data from 0xFF then 0x00; pointer=0x01.
REQ-045 Abort: STOP after 4 bits of a write data byte -> IDLE, no wr_en, sda_oe=0; a subsequent START, 0xA0 is ACKed.
REQ-046 Reset: rst_ref high while sda_oe=1 in WACK -> sda_oe=0 and pointer=0x00 on the next edge.
